// File: rtl/filtro_azar.sv
// filtro_azar: two-flop synchronised glitch filter for one binary signal.
// A new level is accepted after N consecutive synchronised samples. The block
// emits one-cycle pulses for accepted edges and rejected glitches, and keeps
// a saturating count of rejected glitches.
module filtro_azar #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x,
    input  logic          clr,
    output logic          y,
    output logic          rise,
    output logic          fall,
    output logic          glitch,
    output logic [CW-1:0] nglitch
);
    localparam int unsigned     CNTW     = $clog2(N + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(N - 1);

    typedef enum logic {STABLE, PEND} state_t;

    logic            s1_q;
    logic            xs_q;
    state_t          state_q;
    logic [CNTW-1:0] cnt_q;
    logic            y_q;
    logic            rise_q;
    logic            fall_q;
    logic            glitch_q;
    logic [CW-1:0]   nglitch_q;
    logic [CW-1:0]   nglitch_d;
    logic            glitch_det;

    // two-flop synchroniser; only xs_q is seen by the filter
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            xs_q <= 1'b0;
        end else begin
            s1_q <= x;
            xs_q <= s1_q;
        end
    end

    // a pending change is abandoned when xs returns to the held level
    assign glitch_det = (state_q == PEND) && (xs_q == y_q);

    // saturating glitch count; clear wins over a same-cycle glitch
    always_comb begin
        nglitch_d = nglitch_q;
        if (clr) begin
            nglitch_d = '0;
        end else if (glitch_det && (nglitch_q != '1)) begin
            nglitch_d = nglitch_q + CW'(1);
        end
    end

    // filter FSM with registered level, pulses and glitch count
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= STABLE;
            cnt_q     <= '0;
            y_q       <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            glitch_q  <= 1'b0;
            nglitch_q <= '0;
        end else begin
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            glitch_q  <= glitch_det;
            nglitch_q <= nglitch_d;
            case (state_q)
                STABLE: begin
                    if (xs_q != y_q) begin
                        if (N == 1) begin
                            y_q    <= xs_q;
                            rise_q <= xs_q;
                            fall_q <= ~xs_q;
                        end else begin
                            state_q <= PEND;
                            cnt_q   <= CNTW'(1);
                        end
                    end
                end
                PEND: begin
                    if (xs_q == y_q) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        y_q     <= xs_q;
                        rise_q  <= xs_q;
                        fall_q  <= ~xs_q;
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                default: begin
                    state_q <= STABLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign y       = y_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign glitch  = glitch_q;
    assign nglitch = nglitch_q;

endmodule

// File: tb/tb_filtro_azar.sv
// tb_filtro_azar: directed vector table, hand-written corner sequences and
// randomized stimulus checked against a run-length reference model. Two
// instances (CW=8 and CW=2) share all stimulus.
module tb_filtro_azar;
    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       x;
    logic       clr;
    logic       y, rise, fall, glitch;
    logic [7:0] nglitch;
    logic       y2, rise2, fall2, glitch2;
    logic [1:0] nglitch2;

    always #5 clk = ~clk;

    filtro_azar #(.N(4), .CW(8)) dut (
        .clk(clk), .reset(reset), .x(x), .clr(clr),
        .y(y), .rise(rise), .fall(fall), .glitch(glitch), .nglitch(nglitch)
    );

    filtro_azar #(.N(4), .CW(2)) dut2 (
        .clk(clk), .reset(reset), .x(x), .clr(clr),
        .y(y2), .rise(rise2), .fall(fall2), .glitch(glitch2), .nglitch(nglitch2)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // reference model: synchroniser delay line plus a run length of
    // consecutive samples that differ from the accepted level
    logic m_h0, m_h1, m_y, m_rise, m_fall, m_glitch;
    int   m_run, m_ng8, m_ng2;

    task automatic model_step();
        logic xs;
        m_rise = 1'b0; m_fall = 1'b0; m_glitch = 1'b0;
        if (reset) begin
            m_h0 = 1'b0; m_h1 = 1'b0; m_y = 1'b0;
            m_run = 0; m_ng8 = 0; m_ng2 = 0;
        end else begin
            xs   = m_h1;
            m_h1 = m_h0;
            m_h0 = x;
            if (xs != m_y) begin
                m_run++;
                if (m_run == N) begin
                    m_y = xs; m_rise = xs; m_fall = !xs; m_run = 0;
                end
            end else begin
                if (m_run > 0) begin
                    m_glitch = 1'b1;
                    m_ng8 = (m_ng8 < 255) ? m_ng8 + 1 : 255;
                    m_ng2 = (m_ng2 < 3) ? m_ng2 + 1 : 3;
                end
                m_run = 0;
            end
            if (clr) begin
                m_ng8 = 0; m_ng2 = 0;
            end
        end
    endtask

    int n_rise, n_fall, n_glitch, n_yhigh, n_cyc;

    task automatic clear_counts();
        n_rise = 0; n_fall = 0; n_glitch = 0; n_yhigh = 0;
    endtask

    // drive inputs just after an edge, advance one clock, compare 1 ns later
    task automatic tick(input logic r, input logic xv, input logic c);
        reset = r; x = xv; clr = c;
        @(posedge clk);
        model_step();
        #1;
        n_cyc++;
        check($sformatf("model8@%0d", n_cyc), {20'd0, y, rise, fall, glitch, nglitch},
              {20'd0, m_y, m_rise, m_fall, m_glitch, m_ng8[7:0]});
        check($sformatf("model2@%0d", n_cyc), {26'd0, y2, rise2, fall2, glitch2, nglitch2},
              {26'd0, m_y, m_rise, m_fall, m_glitch, m_ng2[1:0]});
        n_rise   += int'(rise);
        n_fall   += int'(fall);
        n_glitch += int'(glitch);
        n_yhigh  += int'(y);
    endtask

    typedef struct {
        logic       r, xv, c;
        logic       ey, er, ef, eg;
        logic [7:0] eng;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic xv, input logic c,
                                input logic ey, input logic er, input logic ef,
                                input logic eg, input logic [7:0] eng);
        vec_t v;
        v.r = r; v.xv = xv; v.c = c;
        v.ey = ey; v.er = er; v.ef = ef; v.eg = eg; v.eng = eng;
        vecs.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic        xr;
        int unsigned len;
        n_cyc = 0;
        reset = 1'b1; x = 1'b0; clr = 1'b0;
        clear_counts();

        // reset with x high, acceptance on the 6th edge after release
        add(1,1,0, 0,0,0,0,0);
        add(1,1,0, 0,0,0,0,0);
        for (int i = 0; i < 5; i++) add(0,1,0, 0,0,0,0,0);
        add(0,1,0, 1,1,0,0,0);
        add(0,1,0, 1,0,0,0,0);
        add(0,1,0, 1,0,0,0,0);
        // clean fall
        for (int i = 0; i < 5; i++) add(0,0,0, 1,0,0,0,0);
        add(0,0,0, 0,0,1,0,0);
        add(0,0,0, 0,0,0,0,0);
        // clean rise held 10 cycles, then fall
        for (int i = 0; i < 5; i++) add(0,1,0, 0,0,0,0,0);
        add(0,1,0, 1,1,0,0,0);
        for (int i = 0; i < 4; i++) add(0,1,0, 1,0,0,0,0);
        for (int i = 0; i < 5; i++) add(0,0,0, 1,0,0,0,0);
        add(0,0,0, 0,0,1,0,0);
        add(0,0,0, 0,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].r, vecs[i].xv, vecs[i].c);
            check($sformatf("vec%0d", i), {20'd0, y, rise, fall, glitch, nglitch},
                  {20'd0, vecs[i].ey, vecs[i].er, vecs[i].ef, vecs[i].eg, vecs[i].eng});
        end

        // high glitches of 1, 2, 3 cycles with y = 0
        clear_counts();
        for (int w = 1; w <= 3; w++) begin
            repeat (w) tick(0, 1, 0);
            repeat (8) tick(0, 0, 0);
        end
        check("hi_glitch_rise", n_rise, 0);
        check("hi_glitch_cnt", n_glitch, 3);
        check("hi_glitch_y", {31'd0, y}, 0);
        check("hi_glitch_ng8", {24'd0, nglitch}, 3);
        check("hi_glitch_ng2", {30'd0, nglitch2}, 3);

        // low glitches with y = 1
        repeat (10) tick(0, 1, 0);
        clear_counts();
        for (int w = 1; w <= 3; w++) begin
            repeat (w) tick(0, 0, 0);
            repeat (8) tick(0, 1, 0);
        end
        check("lo_glitch_fall", n_fall, 0);
        check("lo_glitch_cnt", n_glitch, 3);
        check("lo_glitch_y", {31'd0, y}, 1);
        check("lo_glitch_ng8", {24'd0, nglitch}, 6);
        check("lo_glitch_ng2_sat", {30'd0, nglitch2}, 3);

        // 4-cycle pulse is accepted exactly
        repeat (10) tick(0, 0, 0);
        clear_counts();
        repeat (4) tick(0, 1, 0);
        repeat (10) tick(0, 0, 0);
        check("w4_rise", n_rise, 1);
        check("w4_fall", n_fall, 1);
        check("w4_yhigh", n_yhigh, 4);
        check("w4_glitch", n_glitch, 0);

        // 3-cycle pulse is rejected
        clear_counts();
        repeat (3) tick(0, 1, 0);
        repeat (10) tick(0, 0, 0);
        check("w3_rise", n_rise, 0);
        check("w3_glitch", n_glitch, 1);
        check("w3_ng8", {24'd0, nglitch}, 7);

        // 2 ns pulse between edges is never sampled
        clear_counts();
        tick(0, 0, 0);
        #2 x = 1'b1;
        #2 x = 1'b0;
        repeat (8) tick(0, 0, 0);
        check("short_rise", n_rise, 0);
        check("short_glitch", n_glitch, 0);
        check("short_ng8", {24'd0, nglitch}, 7);

        // saturation then clear in the same cycle as a glitch detection
        check("sat_ng2", {30'd0, nglitch2}, 3);
        tick(0, 1, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 1);
        check("clr_glitch8", {31'd0, glitch}, 1);
        check("clr_glitch2", {31'd0, glitch2}, 1);
        check("clr_ng8", {24'd0, nglitch}, 0);
        check("clr_ng2", {30'd0, nglitch2}, 0);
        tick(0, 0, 0);
        check("glitch_one_cycle", {31'd0, glitch}, 0);

        // reset asserted while a change is pending
        tick(0, 1, 0);
        tick(0, 1, 0);
        tick(0, 0, 0);
        tick(1, 0, 0);
        check("rst_pend_y", {31'd0, y}, 0);
        check("rst_pend_ng8", {24'd0, nglitch}, 0);
        check("rst_pend_glitch", {31'd0, glitch}, 0);
        clear_counts();
        repeat (6) tick(0, 0, 0);
        check("rst_pend_noglitch", n_glitch, 0);
        check("rst_pend_norise", n_rise, 0);
        repeat (6) tick(0, 1, 0);
        check("rst_resume_y", {31'd0, y}, 1);
        check("rst_resume_rise", n_rise, 1);

        // randomized runs with occasional clear and reset
        xr = 1'b1;
        for (int i = 0; i < 800; ) begin
            len = $urandom_range(1, 7);
            xr  = ~xr;
            for (int k = 0; k < int'(len); k++) begin
                tick(($urandom_range(0, 199) == 0), xr, ($urandom_range(0, 15) == 0));
                i++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
